// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control path.
// Also used by the single-cycle control unit through mips_alu_decoder.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11,
    S_FAULT  = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_CLS_ADD   = 2'd0,
    ALU_CLS_SUB   = 2'd1,
    ALU_CLS_FUNCT = 2'd2
  } alu_class_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'd0,
    FAULT_ILLEGAL = 2'd1,
    FAULT_TIMEOUT = 2'd2
  } fault_code_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Shared memory port between the control FSM (master) and the memory (slave).
interface mips_multicycle_ctrl_if;

  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);

endinterface

// File: rtl/mips_alu_decoder.sv
// Maps an ALU operation class (and funct for R-type) to the ALU control code.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  alu_class_t  alu_class_i,
  input  logic [5:0]  funct_i,
  output logic [3:0]  alu_control_o,
  output logic        illegal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (alu_class_i)
      ALU_CLS_ADD: alu_control_o = ALU_ADD;
      ALU_CLS_SUB: alu_control_o = ALU_SUB;
      ALU_CLS_FUNCT: begin
        case (funct_i)
          FUNCT_ADD: alu_control_o = ALU_ADD;
          FUNCT_SUB: alu_control_o = ALU_SUB;
          FUNCT_AND: alu_control_o = ALU_AND;
          FUNCT_OR:  alu_control_o = ALU_OR;
          FUNCT_SLT: alu_control_o = ALU_SLT;
          default: begin
            alu_control_o = ALU_AND;
            illegal_o     = 1'b1;
          end
        endcase
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared req/ready memory port with a wait-state timeout.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter bit EN_ADDI     = 1'b1,
  parameter bit EN_JUMP     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  mips_multicycle_ctrl_if.master mem,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [3:0] state
);

  localparam int             CntW   = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  fault_code_t     fault_code_q, fault_code_d;

  alu_class_t alu_class;
  logic       alu_used;
  logic [3:0] dec_alu;
  logic       dec_illegal;
  logic       mem_req_c, mem_we_c, ir_write_c, pc_en_c, reg_write_c;

  mips_alu_decoder u_alu_dec (
    .alu_class_i   (alu_class),
    .funct_i       (funct),
    .alu_control_o (dec_alu),
    .illegal_o     (dec_illegal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_FETCH;
      wait_cnt_q   <= '0;
      fault_code_q <= FAULT_NONE;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      fault_code_q <= fault_code_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    fault_code_d = fault_code_q;
    mem_req_c    = 1'b0;
    mem_we_c     = 1'b0;
    iord         = 1'b0;
    ir_write_c   = 1'b0;
    pc_en_c      = 1'b0;
    pc_src       = 2'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    alu_class    = ALU_CLS_ADD;
    alu_used     = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write_c  = 1'b0;
    fault        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        alu_src_b = 2'd1;
        alu_used  = 1'b1;
        if (mem.mem_ready) begin
          ir_write_c = 1'b1;
          pc_en_c    = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_used  = 1'b1;
        if (op == OP_LW || op == OP_SW)     state_d = S_MEMADR;
        else if (op == OP_RTYPE)            state_d = S_EXEC;
        else if (op == OP_BEQ)              state_d = S_BRANCH;
        else if (EN_ADDI && op == OP_ADDI)  state_d = S_ADDIEX;
        else if (EN_JUMP && op == OP_J)     state_d = S_JUMP;
        else begin
          state_d      = S_FAULT;
          fault_code_d = FAULT_ILLEGAL;
        end
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_used  = 1'b1;
        state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        if (mem.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c = 1'b1;
        mem_we_c  = 1'b1;
        iord      = 1'b1;
        if (mem.mem_ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_class = ALU_CLS_FUNCT;
        alu_used  = 1'b1;
        if (dec_illegal) begin
          state_d      = S_FAULT;
          fault_code_d = FAULT_ILLEGAL;
        end else begin
          state_d = S_ALUWB;
        end
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        reg_dst     = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_class = ALU_CLS_SUB;
        alu_used  = 1'b1;
        pc_src    = 2'd1;
        pc_en_c   = zero;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        alu_used  = 1'b1;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        pc_src  = 2'd2;
        pc_en_c = 1'b1;
        state_d = S_FETCH;
      end
      S_FAULT: fault = 1'b1;
      default: state_d = S_FAULT;
    endcase

    // A ready on the last allowed wait cycle completes the access instead of faulting.
    if (mem_req_c && !mem.mem_ready && wait_cnt_q == CntMax) begin
      state_d      = S_FAULT;
      fault_code_d = FAULT_TIMEOUT;
    end

    if (state_d != state_q)                 wait_cnt_d = '0;
    else if (mem_req_c && !mem.mem_ready)   wait_cnt_d = wait_cnt_q + CntW'(1);
  end

  // Strobes are masked while reset is held so an access or write is dropped immediately.
  assign mem.mem_req  = mem_req_c & ~reset;
  assign mem.mem_we   = mem_we_c & ~reset;
  assign ir_write     = ir_write_c & ~reset;
  assign pc_en        = pc_en_c & ~reset;
  assign reg_write    = reg_write_c & ~reset;
  assign alu_control  = alu_used ? dec_alu : 4'b0000;
  assign fault_code   = fault_code_q;
  assign state        = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: instruction table with a per-cycle
// expectation scoreboard, plus hand sequences for wait states, timeout, faults and reset.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       memReady;

  logic       iord, irWrite, pcEn, aluSrcA, regDst, memToReg, regWrite, fault;
  logic [1:0] pcSrc, aluSrcB, faultCode;
  logic [3:0] aluControl, dutState;

  logic       iord2, irWrite2, pcEn2, aluSrcA2, regDst2, memToReg2, regWrite2, fault2;
  logic [1:0] pcSrc2, aluSrcB2, faultCode2;
  logic [3:0] aluControl2, dutState2;

  int testsRun = 0;
  int testsFailed = 0;

  mips_multicycle_ctrl_if memIf ();
  mips_multicycle_ctrl_if memIf2 ();
  assign memIf.mem_ready  = memReady;
  assign memIf2.mem_ready = memReady;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .EN_ADDI(1'b1), .EN_JUMP(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem(memIf),
    .iord(iord), .ir_write(irWrite), .pc_en(pcEn), .pc_src(pcSrc),
    .alu_src_a(aluSrcA), .alu_src_b(aluSrcB), .alu_control(aluControl),
    .reg_dst(regDst), .mem_to_reg(memToReg), .reg_write(regWrite),
    .fault(fault), .fault_code(faultCode), .state(dutState)
  );

  mips_multicycle_ctrl #(.MEM_TIMEOUT(16), .EN_ADDI(1'b0), .EN_JUMP(1'b1)) dutNoAddi (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem(memIf2),
    .iord(iord2), .ir_write(irWrite2), .pc_en(pcEn2), .pc_src(pcSrc2),
    .alu_src_a(aluSrcA2), .alu_src_b(aluSrcB2), .alu_control(aluControl2),
    .reg_dst(regDst2), .mem_to_reg(memToReg2), .reg_write(regWrite2),
    .fault(fault2), .fault_code(faultCode2), .state(dutState2)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         cpi;
    logic [19:0] states;
    logic [4:0] reqMask;
    logic [4:0] pcEnMask;
    logic [4:0] regWrMask;
    logic [4:0] m2rMask;
    logic       chkAlu;
    logic [3:0] alu;
  } vec_t;

  typedef struct packed {
    logic [3:0] state;
    logic       memReq;
    logic       pcEn;
    logic       regWrite;
    logic       memToReg;
  } obs_t;

  typedef struct {
    string      name;
    obs_t       obs;
    logic       chkAlu;
    logic [3:0] alu;
  } exp_t;

  vec_t vecs[11];
  exp_t expQ[$];

  function automatic vec_t mkVec(string n, logic [5:0] o, logic [5:0] f, logic z, int cpi,
                                 logic [19:0] sts, logic [4:0] req, logic [4:0] pce,
                                 logic [4:0] rw, logic [4:0] m2r, logic ca, logic [3:0] alu);
    vec_t v;
    v.name = n; v.op = o; v.funct = f; v.zero = z; v.cpi = cpi; v.states = sts;
    v.reqMask = req; v.pcEnMask = pce; v.regWrMask = rw; v.m2rMask = m2r;
    v.chkAlu = ca; v.alu = alu;
    return v;
  endfunction

  task automatic checkVal(string name, logic [31:0] act, logic [31:0] expd);
    testsRun++;
    if (act !== expd) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expd);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    obs_t act;
    testsRun++;
    if (expQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL scoreboard: no expectation queued at t=%0t", $time);
      return;
    end
    e = expQ.pop_front();
    act = '{state: dutState, memReq: memIf.mem_req, pcEn: pcEn, regWrite: regWrite, memToReg: memToReg};
    if (act !== e.obs) begin
      testsFailed++;
      $display("[TB] FAIL %s: got state/req/pc_en/reg_wr/m2r=%h/%b%b%b%b, expected %h/%b%b%b%b",
               e.name, act.state, act.memReq, act.pcEn, act.regWrite, act.memToReg,
               e.obs.state, e.obs.memReq, e.obs.pcEn, e.obs.regWrite, e.obs.memToReg);
    end
    if (e.chkAlu) begin
      testsRun++;
      if (aluControl !== e.alu) begin
        testsFailed++;
        $display("[TB] FAIL %s alu_control: got %b, expected %b", e.name, aluControl, e.alu);
      end
    end
  endtask

  task automatic applyStimulus(vec_t v);
    exp_t e;
    @(negedge clk);
    op = v.op; funct = v.funct; zero = v.zero; memReady = 1'b1;
    for (int c = 0; c < v.cpi; c++) begin
      e.name         = $sformatf("%s c%0d", v.name, c);
      e.obs.state    = v.states[c*4 +: 4];
      e.obs.memReq   = v.reqMask[c];
      e.obs.pcEn     = v.pcEnMask[c];
      e.obs.regWrite = v.regWrMask[c];
      e.obs.memToReg = v.m2rMask[c];
      e.chkAlu       = v.chkAlu && (c == 2);
      e.alu          = v.alu;
      expQ.push_back(e);
    end
    for (int c = 0; c < v.cpi; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checkOutput();
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    memReady = 1'b0;
    reset = 1'b1;
    #1;
    checkVal("reset returns to FETCH", 32'(dutState), 32'(S_FETCH));
    checkVal("reset clears fault", 32'(fault), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  reqCycles, irPulses;
    logic done;
    reset = 1'b1; memReady = 1'b0; op = '0; funct = '0; zero = 1'b0;

    vecs[0]  = mkVec("lw",       OP_LW,    6'h00,     1'b0, 5, 20'h43210, 5'b01001, 5'b00001, 5'b10000, 5'b10000, 1'b1, ALU_ADD);
    vecs[1]  = mkVec("sw",       OP_SW,    6'h00,     1'b0, 4, 20'h05210, 5'b01001, 5'b00001, 5'b00000, 5'b00000, 1'b1, ALU_ADD);
    vecs[2]  = mkVec("add",      OP_RTYPE, FUNCT_ADD, 1'b0, 4, 20'h07610, 5'b00001, 5'b00001, 5'b01000, 5'b00000, 1'b1, 4'b0010);
    vecs[3]  = mkVec("sub",      OP_RTYPE, FUNCT_SUB, 1'b0, 4, 20'h07610, 5'b00001, 5'b00001, 5'b01000, 5'b00000, 1'b1, 4'b0110);
    vecs[4]  = mkVec("and",      OP_RTYPE, FUNCT_AND, 1'b0, 4, 20'h07610, 5'b00001, 5'b00001, 5'b01000, 5'b00000, 1'b1, 4'b0000);
    vecs[5]  = mkVec("or",       OP_RTYPE, FUNCT_OR,  1'b0, 4, 20'h07610, 5'b00001, 5'b00001, 5'b01000, 5'b00000, 1'b1, 4'b0001);
    vecs[6]  = mkVec("slt",      OP_RTYPE, FUNCT_SLT, 1'b0, 4, 20'h07610, 5'b00001, 5'b00001, 5'b01000, 5'b00000, 1'b1, 4'b0111);
    vecs[7]  = mkVec("beq taken",OP_BEQ,   6'h00,     1'b1, 3, 20'h00810, 5'b00001, 5'b00101, 5'b00000, 5'b00000, 1'b1, 4'b0110);
    vecs[8]  = mkVec("beq not",  OP_BEQ,   6'h00,     1'b0, 3, 20'h00810, 5'b00001, 5'b00001, 5'b00000, 5'b00000, 1'b1, 4'b0110);
    vecs[9]  = mkVec("addi",     OP_ADDI,  6'h00,     1'b0, 4, 20'h0A910, 5'b00001, 5'b00001, 5'b01000, 5'b00000, 1'b1, 4'b0010);
    vecs[10] = mkVec("j",        OP_J,     6'h00,     1'b0, 3, 20'h00B10, 5'b00001, 5'b00101, 5'b00000, 5'b00000, 1'b0, 4'b0000);

    repeat (2) @(negedge clk);
    #1;
    checkVal("reset state", 32'(dutState), 32'(S_FETCH));
    checkVal("mem_req masked during reset", 32'(memIf.mem_req), 32'd0);
    checkVal("reset fault", 32'(fault), 32'd0);
    checkVal("reset fault_code", 32'(faultCode), 32'd0);
    checkVal("reset ir_write", 32'(irWrite), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("FETCH mem_req after reset", 32'(memIf.mem_req), 32'd1);
    checkVal("FETCH pc_en while not ready", 32'(pcEn), 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i]);
    checkVal("no fault after legal program", 32'(fault), 32'd0);
    checkVal("EN_ADDI=0 addi parks in FAULT", 32'(dutState2), 32'(S_FAULT));
    checkVal("EN_ADDI=0 addi fault_code", 32'(faultCode2), 32'd1);

    // Fetch with three wait cycles; ready arrives on the last cycle before timeout.
    @(negedge clk);
    op = OP_LW; funct = '0; reqCycles = 0; irPulses = 0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      memReady = (c == 3);
      #1;
      reqCycles += int'(memIf.mem_req);
      irPulses  += int'(irWrite);
    end
    checkVal("fetch wait mem_req cycles", 32'(reqCycles), 32'd4);
    checkVal("fetch wait ir_write pulses", 32'(irPulses), 32'd1);
    checkVal("fetch wait pc_en on ready", 32'(pcEn), 32'd1);
    @(negedge clk);
    #1;
    checkVal("ready on last wait cycle beats timeout", 32'(dutState), 32'(S_DECODE));
    checkVal("no timeout fault", 32'(fault), 32'd0);
    memReady = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      #1;
      if (dutState == S_FETCH) done = 1'b1;
    end
    checkVal("lw after fetch wait returns to FETCH", 32'(done), 32'd1);

    // Timeout: ready held low from the start of this fetch.
    memReady = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkVal("still FETCH on 4th wait cycle", 32'(dutState), 32'(S_FETCH));
    @(negedge clk);
    #1;
    checkVal("timeout state", 32'(dutState), 32'(S_FAULT));
    checkVal("timeout fault", 32'(fault), 32'd1);
    checkVal("timeout fault_code", 32'(faultCode), 32'd2);
    checkVal("timeout drops mem_req", 32'(memIf.mem_req), 32'd0);
    memReady = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkVal("fault is sticky", 32'(dutState), 32'(S_FAULT));
    checkVal("sticky fault_code", 32'(faultCode), 32'd2);
    doReset();
    checkVal("fault_code cleared by reset", 32'(faultCode), 32'd0);

    // Illegal funct in an R-type instruction.
    op = OP_RTYPE; funct = 6'h3F; memReady = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkVal("illegal funct reaches EXEC", 32'(dutState), 32'(S_EXEC));
    @(negedge clk);
    #1;
    checkVal("illegal funct fault", 32'(fault), 32'd1);
    checkVal("illegal funct fault_code", 32'(faultCode), 32'd1);
    doReset();

    // Reset asserted in the middle of a stalled store.
    op = OP_SW; funct = '0; memReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    memReady = 1'b0;
    @(negedge clk);
    #1;
    checkVal("sw stalled in MEMWR", 32'(dutState), 32'(S_MEMWR));
    checkVal("MEMWR mem_req", 32'(memIf.mem_req), 32'd1);
    checkVal("MEMWR mem_we", 32'(memIf.mem_we), 32'd1);
    checkVal("MEMWR iord", 32'(iord), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkVal("reset mid-MEMWR drops mem_req", 32'(memIf.mem_req), 32'd0);
    checkVal("reset mid-MEMWR drops mem_we", 32'(memIf.mem_we), 32'd0);
    checkVal("reset mid-MEMWR state", 32'(dutState), 32'(S_FETCH));
    checkVal("reset mid-MEMWR no pc write", 32'(pcEn), 32'd0);
    checkVal("reset mid-MEMWR no reg write", 32'(regWrite), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
